// File: rtl/router_nport_core.sv
// 1xN byte-serial packet router core: header-decoded destination, per-port FIFOs, parity/length check.
// Optional idle-port flush is enabled by defining ROUTER_SOFT_RESET_EN.
module router_nport_core #(
    parameter int DATA_W     = 8,
    parameter int NUM_PORTS  = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 30
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic [DATA_W-1:0]           data_in,
    input  logic                        pkt_valid,
    input  logic [NUM_PORTS-1:0]        read_enb,
    output logic [NUM_PORTS*DATA_W-1:0] data_out,
    output logic [NUM_PORTS-1:0]        valid_out,
    output logic                        busy,
    output logic                        error
);

    localparam int ADDR_W = ($clog2(NUM_PORTS) > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int LEN_W  = DATA_W - ADDR_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [ADDR_W:0]  PORT_LIMIT = (ADDR_W+1)'(NUM_PORTS);
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_LOAD      = 3'd2;
    localparam logic [2:0] S_WAIT_FULL = 3'd3;
    localparam logic [2:0] S_PARITY    = 3'd4;
    localparam logic [2:0] S_CHECK     = 3'd5;
    localparam logic [2:0] S_DROP      = 3'd6;

    logic [2:0]           state, next_state;
    logic [ADDR_W-1:0]    dest, hdr_dest, sel;
    logic                 hdr_ok, sel_full, sel_flush, wr_en;
    logic                 enter_quiet, drop_quiet;
    logic                 parity_bad, len_bad;
    logic [DATA_W-1:0]    xor_acc, parity_byte, pay_cnt;
    logic [LEN_W-1:0]     exp_len;
    logic [NUM_PORTS-1:0] full, flush;

    assign hdr_dest   = data_in[ADDR_W-1:0];
    assign hdr_ok     = {1'b0, hdr_dest} < PORT_LIMIT;
    assign sel        = (state == S_IDLE) ? hdr_dest : dest;
    assign parity_bad = (xor_acc != parity_byte);
    assign len_bad    = (pay_cnt != {{ADDR_W{1'b0}}, exp_len});

    // In IDLE the port of interest comes straight off the header byte, afterwards from the latched dest.
    always_comb begin
        sel_full  = 1'b0;
        sel_flush = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (sel == ADDR_W'(p)) begin
                sel_full  = full[p];
                sel_flush = flush[p];
            end
        end
    end

    // DECODE, LOAD and WAIT_FULL share one datapath: write when room, hold the source when full.
    always_comb begin
        next_state  = state;
        wr_en       = 1'b0;
        busy        = 1'b0;
        error       = 1'b0;
        enter_quiet = 1'b0;
        case (state)
            S_IDLE: begin
                if (pkt_valid) begin
                    if (!hdr_ok) begin
                        next_state = S_DROP;
                    end else if (sel_flush) begin
                        next_state  = S_DROP;
                        enter_quiet = 1'b1;
                    end else if (sel_full) begin
                        busy = 1'b1;
                    end else begin
                        wr_en      = 1'b1;
                        next_state = S_DECODE;
                    end
                end
            end
            S_DECODE, S_LOAD, S_WAIT_FULL: begin
                if (sel_flush) begin
                    enter_quiet = 1'b1;
                    next_state  = pkt_valid ? S_DROP : S_IDLE;
                end else if (sel_full) begin
                    busy       = 1'b1;
                    next_state = S_WAIT_FULL;
                end else begin
                    wr_en      = 1'b1;
                    next_state = pkt_valid ? S_LOAD : S_PARITY;
                end
            end
            S_PARITY: begin
                next_state = S_CHECK;
            end
            S_CHECK: begin
                busy       = 1'b1;
                error      = parity_bad || len_bad;
                next_state = S_IDLE;
            end
            S_DROP: begin
                if (!pkt_valid) begin
                    error      = !drop_quiet;
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            dest        <= '0;
            xor_acc     <= '0;
            parity_byte <= '0;
            pay_cnt     <= '0;
            exp_len     <= '0;
            drop_quiet  <= 1'b0;
        end else begin
            state <= next_state;
            if (wr_en) begin
                if (state == S_IDLE) begin
                    dest    <= hdr_dest;
                    xor_acc <= data_in;
                    pay_cnt <= '0;
                    exp_len <= data_in[DATA_W-1:ADDR_W];
                end else if (pkt_valid) begin
                    xor_acc <= xor_acc ^ data_in;
                    if (pay_cnt != '1) begin
                        pay_cnt <= pay_cnt + DATA_W'(1);
                    end
                end else begin
                    parity_byte <= data_in;
                end
            end
            if (next_state == S_DROP && state != S_DROP) begin
                drop_quiet <= enter_quiet;
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [DATA_W-1:0] mem [FIFO_DEPTH];
        logic [PTR_W-1:0]  wr_ptr, rd_ptr;
        logic [CNT_W-1:0]  count, count_nxt;
        logic [DATA_W-1:0] lane_q;
        logic              vld_q, wr, rd;

        assign wr      = wr_en && (sel == ADDR_W'(p));
        assign rd      = read_enb[p] && (count != '0);
        assign full[p] = (count == DEPTH_C);

        always_comb begin
            count_nxt = count;
            if (flush[p]) begin
                count_nxt = '0;
            end else if (wr && !rd) begin
                count_nxt = count + CNT_W'(1);
            end else if (!wr && rd) begin
                count_nxt = count - CNT_W'(1);
            end
        end

        // valid_out follows the post-update count so it drops right after the final read.
        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                lane_q <= '0;
                vld_q  <= 1'b0;
            end else begin
                if (flush[p]) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                end else begin
                    if (wr) begin
                        wr_ptr <= wr_ptr + PTR_W'(1);
                    end
                    if (rd) begin
                        rd_ptr <= rd_ptr + PTR_W'(1);
                        lane_q <= mem[rd_ptr];
                    end
                end
                count <= count_nxt;
                vld_q <= (count_nxt != '0);
            end
        end

        always_ff @(posedge clock) begin
            if (wr) begin
                mem[wr_ptr] <= data_in;
            end
        end

        assign data_out[p*DATA_W +: DATA_W] = lane_q;
        assign valid_out[p]                 = vld_q;

`ifdef ROUTER_SOFT_RESET_EN
        localparam int TO_W = $clog2(TIMEOUT + 1);
        logic [TO_W-1:0] idle_cnt;

        assign flush[p] = vld_q && !read_enb[p] && (idle_cnt == TO_W'(TIMEOUT - 1));

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                idle_cnt <= '0;
            end else if (!vld_q || read_enb[p] || flush[p]) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + TO_W'(1);
            end
        end
`else
        assign flush[p] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_router_nport_core.sv
// Scoreboard bench for router_nport_core: expected bytes queued per port at send time, checked on read.
module tb_router_nport_core;

    localparam int DW    = 8;
    localparam int NP    = 3;
    localparam int DEPTH = 16;
    localparam int TO    = 30;

    logic             clock = 1'b0;
    logic             resetn;
    logic [DW-1:0]    data_in;
    logic             pkt_valid;
    logic [NP-1:0]    read_enb;
    logic [NP*DW-1:0] data_out;
    logic [NP-1:0]    valid_out;
    logic             busy;
    logic             error;

    int errors  = 0;
    int checks  = 0;
    int cyc_cnt = 0;
    int hdr_cyc = 0;
    int acc_n   = 0;

    logic [7:0]    pkt [0:63];
    int            pkt_n;
    logic [7:0]    sb0 [$];
    logic [7:0]    sb1 [$];
    logic [7:0]    sb2 [$];
    logic [NP-1:0] rd_mask    = '0;
    logic [NP-1:0] rd_pending = '0;

    router_nport_core #(
        .DATA_W(DW), .NUM_PORTS(NP), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .resetn(resetn), .data_in(data_in), .pkt_valid(pkt_valid),
        .read_enb(read_enb), .data_out(data_out), .valid_out(valid_out),
        .busy(busy), .error(error)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    function automatic void sb_push(int p, logic [7:0] b);
        case (p)
            0: sb0.push_back(b);
            1: sb1.push_back(b);
            2: sb2.push_back(b);
            default: ;
        endcase
    endfunction

    function automatic logic [7:0] sb_pop(int p);
        case (p)
            0: return sb0.pop_front();
            1: return sb1.pop_front();
            2: return sb2.pop_front();
            default: return 8'h00;
        endcase
    endfunction

    function automatic int sb_size(int p);
        case (p)
            0: return sb0.size();
            1: return sb1.size();
            2: return sb2.size();
            default: return 0;
        endcase
    endfunction

    function automatic void sb_clear(int p);
        case (p)
            0: sb0.delete();
            1: sb1.delete();
            2: sb2.delete();
            default: ;
        endcase
    endfunction

    function automatic logic [7:0] calc_par();
        logic [7:0] par;
        par = 8'h00;
        for (int i = 0; i < pkt_n - 1; i++) par = par ^ pkt[i];
        return par;
    endfunction

    // Background reader: drains masked ports and checks every returned byte against the scoreboard.
    initial begin
        logic [7:0] exp_b;
        read_enb = '0;
        forever begin
            @(posedge clock);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (rd_pending[p]) begin
                    checks++;
                    if (sb_size(p) == 0) begin
                        errors++;
                        $display("[TB] FAIL read_extra port %0d: got %h, expected no more data", p, data_out[p*DW +: DW]);
                    end else begin
                        exp_b = sb_pop(p);
                        if (data_out[p*DW +: DW] !== exp_b) begin
                            errors++;
                            $display("[TB] FAIL read_data port %0d: got %h, expected %h", p, data_out[p*DW +: DW], exp_b);
                        end
                    end
                end
            end
            read_enb   = rd_mask & valid_out;
            rd_pending = read_enb;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_packet(input int dest, output int err_cnt, output int busy_cnt);
        int   tries;
        logic took;
        err_cnt  = 0;
        busy_cnt = 0;
        acc_n    = 0;
        for (int i = 0; i < pkt_n; i++) begin
            data_in   = pkt[i];
            pkt_valid = (i < pkt_n - 1);
            took      = 1'b0;
            tries     = 0;
            while (!took && tries < 200) begin
                @(negedge clock);
                if (busy)  busy_cnt++;
                if (error) err_cnt++;
                took = !busy;
                step();
                tries++;
            end
            if (!took) begin
                errors++;
                checks++;
                $display("[TB] FAIL byte_accept idx %0d: busy held for %0d cycles, expected release", i, tries);
                break;
            end
            if (dest < NP) sb_push(dest, pkt[i]);
            acc_n++;
            if (i == 0) hdr_cyc = cyc_cnt;
        end
        pkt_valid = 1'b0;
        data_in   = '0;
        repeat (4) begin
            @(negedge clock);
            if (busy)  busy_cnt++;
            if (error) err_cnt++;
            step();
        end
    endtask

    task automatic drain(input int p);
        int n;
        n = 0;
        rd_mask[p] = 1'b1;
        while (n < 300) begin
            step();
            #1;
            n++;
            if (!valid_out[p] && !rd_pending[p]) break;
        end
        rd_mask[p] = 1'b0;
        checks++;
        if (n >= 300) begin
            errors++;
            $display("[TB] FAIL drain_timeout port %0d: valid_out still %b after %0d cycles", p, valid_out[p], n);
        end
        checks++;
        if (sb_size(p) != 0) begin
            errors++;
            $display("[TB] FAIL drain_left port %0d: %0d bytes never read, expected 0", p, sb_size(p));
        end
        step();
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        pkt_valid = 1'b0;
        data_in   = '0;
        repeat (2) @(negedge clock);
        check_int("reset_busy", int'(busy), 0);
        check_int("reset_error", int'(error), 0);
        check_int("reset_valid_out", int'(valid_out), 0);
        check_int("reset_data_out", int'(data_out), 0);
        step();
        resetn = 1'b1;
        step();
    endtask

    task automatic test_good_packet();
        int e, b;
        pkt[0] = 8'h0D; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33;
        pkt_n = 5;
        pkt[4] = calc_par();
        drive_packet(1, e, b);
        check_int("good_error", e, 0);
        check_int("good_busy_cycles", b, 1);
        check_int("good_valid_out", int'(valid_out), 3'b010);
        drain(1);
        check_int("good_valid_after_drain", int'(valid_out), 0);
    endtask

    task automatic test_bad_parity();
        int e, b;
        pkt[0] = 8'h0D; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33;
        pkt_n = 5;
        pkt[4] = calc_par() ^ 8'h01;
        drive_packet(1, e, b);
        check_int("badpar_error_pulses", e, 1);
        check_int("badpar_busy_cycles", b, 1);
        check_int("badpar_valid_out", int'(valid_out), 3'b010);
        drain(1);
    endtask

    task automatic test_length_mismatch();
        int e, b;
        pkt[0] = 8'h0D; pkt[1] = 8'h11; pkt[2] = 8'h22;
        pkt_n = 4;
        pkt[3] = calc_par();
        drive_packet(1, e, b);
        check_int("badlen_error_pulses", e, 1);
        drain(1);
    endtask

    task automatic test_zero_length();
        int e, b;
        pkt[0] = 8'h02;
        pkt_n = 2;
        pkt[1] = calc_par();
        drive_packet(2, e, b);
        check_int("zerolen_error", e, 0);
        check_int("zerolen_valid_out", int'(valid_out), 3'b100);
        drain(2);
    endtask

    task automatic test_bad_dest();
        int e, b;
        pkt[0] = 8'h03; pkt[1] = 8'hAA;
        pkt_n = 3;
        pkt[2] = calc_par();
        drive_packet(3, e, b);
        check_int("baddest_error_pulses", e, 1);
        check_int("baddest_busy_cycles", b, 0);
        check_int("baddest_valid_out", int'(valid_out), 0);
    endtask

    task automatic test_back_to_back_full();
        int e, b;
        pkt[0] = 8'h50;
        for (int i = 1; i <= 20; i++) pkt[i] = 8'h40 + 8'(i);
        pkt_n = 22;
        pkt[21] = calc_par();
        fork
            drive_packet(0, e, b);
            begin
                int   n;
                logic seen;
                n    = 0;
                seen = 1'b0;
                while (!seen && n < 200) begin
                    @(negedge clock);
                    if (busy) seen = 1'b1;
                    else n++;
                end
                check_int("full_busy_seen", int'(seen), 1);
                check_int("full_busy_at_count", acc_n, DEPTH);
                repeat (3) step();
                rd_mask[0] = 1'b1;
            end
        join
        check_int("full_error", e, 0);
        check_int("full_bytes_accepted", acc_n, 22);
        drain(0);
    endtask

    task automatic test_soft_reset();
        int e, b, c0, guard;
        pkt[0] = 8'h02;
        pkt_n = 2;
        pkt[1] = calc_par();
        drive_packet(2, e, b);
        c0 = hdr_cyc;
        pkt[0] = 8'h08; pkt[1] = 8'h55; pkt[2] = 8'h66;
        pkt_n = 4;
        pkt[3] = calc_par();
        drive_packet(0, e, b);
        guard = 0;
        while (cyc_cnt < c0 + TO - 1 && guard < 100) begin
            step();
            guard++;
        end
        check_int("soft_port2_before_timeout", int'(valid_out[2]), 1);
        step();
`ifdef ROUTER_SOFT_RESET_EN
        check_int("soft_port2_at_timeout", int'(valid_out[2]), 0);
        sb_clear(2);
`else
        check_int("soft_port2_at_timeout", int'(valid_out[2]), 1);
`endif
        check_int("soft_port0_kept", int'(valid_out[0]), 1);
        drain(0);
        drain(2);
    endtask

    task automatic test_reset_mid_packet();
        pkt_valid = 1'b1;
        data_in   = 8'h0D;
        step();
        data_in   = 8'h11;
        step();
        resetn    = 1'b0;
        pkt_valid = 1'b0;
        data_in   = '0;
        #2;
        check_int("midrst_valid_out", int'(valid_out), 0);
        check_int("midrst_busy", int'(busy), 0);
        check_int("midrst_error", int'(error), 0);
        check_int("midrst_data_out", int'(data_out), 0);
        step();
        resetn = 1'b1;
        step();
        check_int("midrst_fifo_empty", int'(valid_out), 0);
        test_good_packet();
    endtask

    initial begin
        pkt_valid = 1'b0;
        data_in   = '0;
        resetn    = 1'b0;
        test_reset();
        test_good_packet();
        test_bad_parity();
        test_length_mismatch();
        test_zero_length();
        test_bad_dest();
        test_back_to_back_full();
        test_soft_reset();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
